// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. One GROUP-bit lookahead slice per stage,
// with the inter-slice carry and unconsumed operand bits registered between stages.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Carryin,
  input  logic             Sub,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Sum,
  output logic             Carryout,
  output logic             Overflow,
  output logic             Zero
);

  localparam int unsigned NSTAGE = WIDTH / GROUP;

  // Flat two-level lookahead: c[i+1] = OR over j of (gx[j] & p[j..i]), gx = {g, cin}.
  function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] a,
                                                 input logic [GROUP-1:0] b,
                                                 input logic             cin);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   gx;
    logic [GROUP:0]   c;
    logic             term;
    g    = a & b;
    p    = a | b;
    gx   = {g, cin};
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(GROUP); i++) begin
      for (int j = 0; j <= i + 1; j++) begin
        term = gx[j];
        for (int k = j; k <= i; k++) begin
          term = term & p[k];
        end
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;
  logic             overflow_q;
  logic             zero_q;

  assign advance = ~OutValid | OutReady;
  assign InReady = advance;
  assign b_eff   = Sub ? ~B : B;
  assign cin0    = Sub | Carryin;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int unsigned SW = (k + 1) * GROUP;

    logic [GROUP-1:0] a_sl;
    logic [GROUP-1:0] b_sl;
    logic             cin_sl;
    logic             valid_in;
    logic [GROUP:0]   c;
    logic [GROUP-1:0] s;
    logic [SW-1:0]    sum_d;
    logic [SW-1:0]    sum_q;
    logic             valid_q;
    logic             carry_q;

    if (k == 0) begin : g_src
      assign a_sl     = A[GROUP-1:0];
      assign b_sl     = b_eff[GROUP-1:0];
      assign cin_sl   = cin0;
      assign valid_in = InValid;
      assign sum_d    = s;
    end else begin : g_src
      assign a_sl     = g_stage[k-1].g_pass.a_q[GROUP-1:0];
      assign b_sl     = g_stage[k-1].g_pass.b_q[GROUP-1:0];
      assign cin_sl   = g_stage[k-1].carry_q;
      assign valid_in = g_stage[k-1].valid_q;
      assign sum_d    = {s, g_stage[k-1].sum_q};
    end

    assign c = cla_carries(a_sl, b_sl, cin_sl);
    assign s = a_sl ^ b_sl ^ c[GROUP-1:0];

    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (advance) begin
        valid_q <= valid_in;
        sum_q   <= sum_d;
        carry_q <= c[GROUP];
      end
    end

    // Upper operand bits still waiting for their slice; B is already conditionally inverted.
    if (k < NSTAGE - 1) begin : g_pass
      localparam int unsigned REM = WIDTH - SW;
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      if (k == 0) begin : g_in
        assign a_d = A[WIDTH-1:GROUP];
        assign b_d = b_eff[WIDTH-1:GROUP];
      end else begin : g_in
        assign a_d = g_stage[k-1].g_pass.a_q[REM+GROUP-1:GROUP];
        assign b_d = g_stage[k-1].g_pass.b_q[REM+GROUP-1:GROUP];
      end

      always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == NSTAGE - 1) begin : g_flags
      always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
          overflow_q <= 1'b0;
          zero_q     <= 1'b0;
        end else if (advance) begin
          overflow_q <= c[GROUP-1] ^ c[GROUP];
          zero_q     <= ~|sum_d;
        end
      end
    end
  end

  assign OutValid = g_stage[NSTAGE-1].valid_q;
  assign Sum      = g_stage[NSTAGE-1].sum_q;
  assign Carryout = g_stage[NSTAGE-1].carry_q;
  assign Overflow = overflow_q;
  assign Zero     = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed vectors, backpressure and mid-stream reset on a
// 32/8 instance, plus randomized sweeps of 16/4, 32/32 and 64/8 against an arithmetic model.
module tb_pipelined_cla_adder;

  typedef struct packed {
    logic [63:0] sum;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  localparam int NOPS = 1000;

  int checks;
  int errors;
  int sweep_done;
  bit sweep_go;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) u_dut (
    .Clock(clk), .Resetn(rst_n), .InValid(in_valid), .InReady(in_ready),
    .A(op_a), .B(op_b), .Carryin(cin), .Sub(sub),
    .OutValid(out_valid), .OutReady(out_ready), .Sum(sum),
    .Carryout(cout), .Overflow(ovf), .Zero(zero)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Result of w-bit a +/- b from plain integer arithmetic.
  function automatic res_t ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                     input logic ci, input logic sb);
    logic [63:0]        mask;
    logic [64:0]        full;
    logic signed [65:0] sa;
    logic signed [65:0] sbv;
    logic signed [65:0] sr;
    logic signed [65:0] lim;
    res_t               r;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    a    = a & mask;
    b    = b & mask;
    if (sb) begin
      full = {1'b0, a} - {1'b0, b};
      r.c  = (a >= b);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {64'd0, ci};
      r.c  = full[w];
    end
    r.sum = full[63:0] & mask;
    sa    = $signed({2'b00, a});
    sbv   = $signed({2'b00, b});
    if (a[w-1]) sa = sa - ($signed(66'd1) <<< w);
    if (b[w-1]) sbv = sbv - ($signed(66'd1) <<< w);
    sr  = sb ? (sa - sbv) : (sa + sbv + $signed({65'd0, ci}));
    lim = $signed(66'd1) <<< (w - 1);
    r.v = (sr >= lim) || (sr < -lim);
    r.z = (r.sum == 64'd0);
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // One isolated operation: checks acceptance, latency, result and the drain.
  task automatic run_one(input string name, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tc, input logic ts, input res_t exp);
    int lat;
    out_ready = 1'b1;
    op_a = ta; op_b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    #1;
    check({name, "_inready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = $urandom(); op_b = $urandom(); cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, lat, 3);
    check({name, "_sum"}, 64'(sum), exp.sum);
    check({name, "_cout"}, cout, exp.c);
    check({name, "_ovf"}, ovf, exp.v);
    check({name, "_zero"}, zero, exp.z);
    @(posedge clk); #1;
    check({name, "_drain"}, out_valid, 0);
  endtask

  vec_t vecs[9];
  res_t bp_q[$];

  initial begin : main
    res_t        e;
    logic [31:0] ca, cb, held;
    logic        cc, cs, stalled;
    int          sent, recv, seen;
    checks = 0; errors = 0; sweep_done = 0; sweep_go = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_outvalid", out_valid, 0);
    check("rst_sum", 64'(sum), 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 0);
    check("rst_inready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      e = '{64'(vecs[i].s), vecs[i].c, vecs[i].v, vecs[i].z};
      run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, e);
    end

    // Backpressure: OutReady low for cycles 2..9 of an 8-op stream.
    sent = 0; recv = 0; stalled = 1'b0; held = '0;
    ca = $urandom(); cb = $urandom(); cc = 1'($urandom_range(0, 1));
    cs = 1'($urandom_range(0, 1));
    for (int c = 0; c < 40 && recv < 8; c++) begin
      in_valid  = (sent < 8);
      op_a = ca; op_b = cb; cin = cc; sub = cs;
      out_ready = !(c >= 2 && c <= 9);
      @(negedge clk);
      if (out_valid && !out_ready) begin
        check("bp_inready", in_ready, 0);
        if (stalled) check("bp_hold", 64'(sum), 64'(held));
        held    = sum;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (c >= 10 && recv < 8) check("bp_nogap", out_valid, 1);
      if (out_valid && out_ready) begin
        if (bp_q.size() == 0) begin
          check("bp_spurious", out_valid, 0);
        end else begin
          e = bp_q.pop_front();
          check("bp_sum", 64'(sum), e.sum);
          check("bp_cout", cout, e.c);
          check("bp_ovf", ovf, e.v);
          check("bp_zero", zero, e.z);
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        bp_q.push_back(ref_model(32, 64'(ca), 64'(cb), cc, cs));
        sent++;
        ca = $urandom(); cb = $urandom(); cc = 1'($urandom_range(0, 1));
        cs = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_count", recv, 8);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset with three operations in flight, the oldest sitting stalled at the output.
    for (int i = 0; i < 3; i++) begin
      op_a = 32'h1111_1111 * (i + 1); op_b = 32'h0101_0101; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("rstmid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_outvalid", out_valid, 0);
    check("rstmid_sum", 64'(sum), 0);
    check("rstmid_inready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rstmid_ghosts", seen, 0);
    run_one("rstmid_next", 32'hDEAD_BEEF, 32'h0000_0011, 1'b1, 1'b0,
            '{64'hDEAD_BF01, 1'b0, 1'b0, 1'b0});

    sweep_go = 1'b1;
    wait (sweep_done == 3);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int unsigned W = (gi == 0) ? 16 : ((gi == 1) ? 32 : 64);
    localparam int unsigned G = (gi == 0) ? 4 : ((gi == 1) ? 32 : 8);

    logic         iv, ir, cn, sb, ovo, ordy, co, vf, zr;
    logic [W-1:0] ta, tbv, sm;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) u_dut (
      .Clock(clk), .Resetn(rst_n), .InValid(iv), .InReady(ir),
      .A(ta), .B(tbv), .Carryin(cn), .Sub(sb),
      .OutValid(ovo), .OutReady(ordy), .Sum(sm),
      .Carryout(co), .Overflow(vf), .Zero(zr)
    );

    initial begin : run
      res_t         q[$];
      res_t         e;
      logic [W-1:0] ca, cb;
      logic         cc, cs;
      int           sent, recv, cyc;
      iv = 1'b0; ordy = 1'b0; ta = '0; tbv = '0; cn = 1'b0; sb = 1'b0;
      wait (sweep_go);
      @(posedge clk); #1;
      sent = 0; recv = 0; cyc = 0;
      ca = W'(rnd64()); cb = W'(rnd64()); cc = 1'($urandom_range(0, 1));
      cs = 1'($urandom_range(0, 1));
      while (recv < NOPS && cyc < NOPS * 10) begin
        iv = (sent < NOPS) && ($urandom_range(0, 3) != 0);
        if (iv) begin
          ta = ca; tbv = cb; cn = cc; sb = cs;
        end else begin
          ta = W'(rnd64()); tbv = W'(rnd64()); cn = 1'($urandom_range(0, 1));
          sb = 1'($urandom_range(0, 1));
        end
        ordy = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (ovo && ordy) begin
          if (q.size() == 0) begin
            check($sformatf("sw%0d_spurious", gi), ovo, 0);
          end else begin
            e = q.pop_front();
            check($sformatf("sw%0d_sum", gi), 64'(sm), e.sum);
            check($sformatf("sw%0d_cout", gi), co, e.c);
            check($sformatf("sw%0d_ovf", gi), vf, e.v);
            check($sformatf("sw%0d_zero", gi), zr, e.z);
          end
          recv++;
        end
        if (iv && ir) begin
          q.push_back(ref_model(W, 64'(ca), 64'(cb), cc, cs));
          sent++;
          ca = W'(rnd64()); cb = W'(rnd64()); cc = 1'($urandom_range(0, 1));
          cs = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        cyc++;
      end
      iv = 1'b0;
      check($sformatf("sw%0d_count", gi), recv, NOPS);
      sweep_done++;
    end
  end

endmodule
